// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: source indices, widths and the buffer entry.
// Data width follows the global GRLEN macro (32 if not supplied by the build).
`ifndef GRLEN
`define GRLEN 32
`endif

package wb_arbiter_pkg;

  localparam int unsigned DATA_W  = `GRLEN;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned NUM_REG = 32;
  localparam int unsigned NUM_SRC = 3;

  typedef enum logic [1:0] {
    SRC_LSU = 2'd0,
    SRC_MDU = 2'd1,
    SRC_ALU = 2'd2
  } src_e;

  typedef struct packed {
    logic              full;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Round-robin successor: LSU -> MDU -> ALU -> LSU
  function automatic src_e next_src(input src_e s);
    case (s)
      SRC_LSU: return SRC_MDU;
      SRC_MDU: return SRC_ALU;
      default: return SRC_LSU;
    endcase
  endfunction

endpackage

// File: rtl/wb_src_buf.sv
// One-entry result buffer for a single writeback source.
// Accepts whenever empty or being drained; rd==0 entries self-drain without a grant.
module wb_src_buf
  import wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  input  logic [RD_W-1:0]   rd,
  input  logic [DATA_W-1:0] data,
  input  logic              grant,
  output logic              ready_c,
  output wb_entry_t         entry
);

  logic drain_c;

  assign drain_c = entry.full & (grant | (entry.rd == '0));
  assign ready_c = !entry.full | drain_c;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entry <= '0;
    end else if (valid && ready_c) begin
      entry <= '{full: 1'b1, rd: rd, data: data};
    end else if (drain_c) begin
      entry <= '0;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: three buffered sources, round-robin onto two register-file write ports.
// Define WB_STALL_CNT_EN to build the arbitration stall counter; otherwise stall_cnt is 0.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [RD_W-1:0]     lsu_rd,
  input  logic [DATA_W-1:0]   lsu_data,
  input  logic                mdu_valid,
  output logic                mdu_ready,
  input  logic [RD_W-1:0]     mdu_rd,
  input  logic [DATA_W-1:0]   mdu_data,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [RD_W-1:0]     alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                wen1,
  output logic [RD_W-1:0]     waddr1,
  output logic [DATA_W-1:0]   wdata1,
  output logic                wen2,
  output logic [RD_W-1:0]     waddr2,
  output logic [DATA_W-1:0]   wdata2,
  output logic [NUM_REG-1:0]  pend_mask,
  output logic [31:0]         stall_cnt
);

  logic [NUM_SRC-1:0] vld;
  logic [NUM_SRC-1:0] rdy;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] cand;
  logic [RD_W-1:0]    in_rd   [NUM_SRC];
  logic [DATA_W-1:0]  in_data [NUM_SRC];
  wb_entry_t          ent     [NUM_SRC];

  src_e rr, rr_nxt, idx, last;
  src_e ord [NUM_SRC];
  logic found1, found2, blocked, stall_c;
  logic [RD_W-1:0]   p1_rd, p2_rd;
  logic [DATA_W-1:0] p1_data, p2_data;

  assign vld = {alu_valid, mdu_valid, lsu_valid};
  assign in_rd[SRC_LSU]   = lsu_rd;
  assign in_rd[SRC_MDU]   = mdu_rd;
  assign in_rd[SRC_ALU]   = alu_rd;
  assign in_data[SRC_LSU] = lsu_data;
  assign in_data[SRC_MDU] = mdu_data;
  assign in_data[SRC_ALU] = alu_data;

  assign lsu_ready = rdy[SRC_LSU];
  assign mdu_ready = rdy[SRC_MDU];
  assign alu_ready = rdy[SRC_ALU];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_buf
    wb_src_buf u_buf (
      .clk     (clk),
      .resetn  (resetn),
      .valid   (vld[i]),
      .rd      (in_rd[i]),
      .data    (in_data[i]),
      .grant   (grant[i]),
      .ready_c (rdy[i]),
      .entry   (ent[i])
    );
    assign cand[i] = ent[i].full & (ent[i].rd != '0);
  end

  // Pending-write mask from buffer contents only; r0 never reported
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ent[i].full) pend_mask[ent[i].rd] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  // Scan from rr; a same-rd second candidate blocks the scan rather than being skipped
  always_comb begin
    ord[0]  = rr;
    ord[1]  = next_src(rr);
    ord[2]  = next_src(next_src(rr));
    idx     = rr;
    last    = rr;
    found1  = 1'b0;
    found2  = 1'b0;
    blocked = 1'b0;
    grant   = '0;
    p1_rd   = '0;
    p1_data = '0;
    p2_rd   = '0;
    p2_data = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      idx = ord[j];
      if (cand[idx]) begin
        if (!found1) begin
          found1     = 1'b1;
          grant[idx] = 1'b1;
          last       = idx;
          p1_rd      = ent[idx].rd;
          p1_data    = ent[idx].data;
        end else if (!found2 && !blocked) begin
          if (ent[idx].rd != p1_rd) begin
            found2     = 1'b1;
            grant[idx] = 1'b1;
            last       = idx;
            p2_rd      = ent[idx].rd;
            p2_data    = ent[idx].data;
          end else begin
            blocked = 1'b1;
          end
        end
      end
    end
    rr_nxt  = found1 ? next_src(last) : rr;
    stall_c = |(cand & ~grant);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr     <= SRC_LSU;
      wen1   <= 1'b0;
      waddr1 <= '0;
      wdata1 <= '0;
      wen2   <= 1'b0;
      waddr2 <= '0;
      wdata2 <= '0;
    end else begin
      rr     <= rr_nxt;
      wen1   <= found1;
      waddr1 <= p1_rd;
      wdata1 <= p1_data;
      wen2   <= found2;
      waddr2 <= p2_rd;
      wdata2 <= p2_data;
    end
  end

`ifdef WB_STALL_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (stall_c) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
  logic unused_stall;
  assign unused_stall = stall_c;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with hand-computed expectations.
`timescale 1ns/1ps
module tb_wb_arbiter;

  localparam int unsigned DW = `GRLEN;

  logic          clk = 1'b0;
  logic          resetn;
  logic          lsu_valid, mdu_valid, alu_valid;
  logic          lsu_ready, mdu_ready, alu_ready;
  logic [4:0]    lsu_rd, mdu_rd, alu_rd;
  logic [DW-1:0] lsu_data, mdu_data, alu_data;
  logic          wen1, wen2;
  logic [4:0]    waddr1, waddr2;
  logic [DW-1:0] wdata1, wdata2;
  logic [31:0]   pend_mask, stall_cnt;

  int vectors = 0;
  int miscompares = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk(clk), .resetn(resetn),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .wen2(wen2), .waddr2(waddr2), .wdata2(wdata2),
    .pend_mask(pend_mask), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lsu_valid = 0; mdu_valid = 0; alu_valid = 0;
  endtask

  task automatic stall_inc();
`ifdef WB_STALL_CNT_EN
    exp_stall++;
`endif
  endtask

  initial begin
    resetn = 0;
    lsu_valid = 1; mdu_valid = 1; alu_valid = 1;
    lsu_rd = 5'd1; mdu_rd = 5'd2; alu_rd = 5'd3;
    lsu_data = 'h11; mdu_data = 'h22; alu_data = 'h33;

    // Reset held with all valids high
    repeat (3) tick();
    chk("rst_wen1", 64'(wen1), 0);
    chk("rst_wen2", 64'(wen2), 0);
    chk("rst_waddr1", 64'(waddr1), 0);
    chk("rst_wdata1", 64'(wdata1), 0);
    chk("rst_pend", 64'(pend_mask), 0);
    chk("rst_stall", 64'(stall_cnt), 0);
    chk("rst_ready", 64'({lsu_ready, mdu_ready, alu_ready}), 64'h7);
    idle();
    resetn = 1;
    tick();
    chk("post_rst_pend", 64'(pend_mask), 0);
    chk("post_rst_wen1", 64'(wen1), 0);

    // Single ALU write
    alu_valid = 1; alu_rd = 5'd5; alu_data = 'h1234;
    tick();
    idle();
    chk("single_pend", 64'(pend_mask), 64'h20);
    tick();
    chk("single_wen1", 64'(wen1), 1);
    chk("single_waddr1", 64'(waddr1), 5);
    chk("single_wdata1", 64'(wdata1), 'h1234);
    chk("single_wen2", 64'(wen2), 0);
    chk("single_pend_clr", 64'(pend_mask), 0);
    tick();
    chk("single_done", 64'(wen1), 0);

    // Three distinct rds, rr at LSU
    lsu_valid = 1; lsu_rd = 5'd3; lsu_data = 'h33;
    mdu_valid = 1; mdu_rd = 5'd4; mdu_data = 'h44;
    alu_valid = 1; alu_rd = 5'd7; alu_data = 'h77;
    tick();
    idle();
    chk("tri_pend", 64'(pend_mask), 64'h98);
    chk("tri_alu_ready", 64'(alu_ready), 0);
    chk("tri_mdu_ready", 64'(mdu_ready), 1);
    stall_inc();
    tick();
    chk("tri_c2_p1", 64'({wen1, waddr1}), 64'({1'b1, 5'd3}));
    chk("tri_c2_d1", 64'(wdata1), 'h33);
    chk("tri_c2_p2", 64'({wen2, waddr2}), 64'({1'b1, 5'd4}));
    chk("tri_c2_d2", 64'(wdata2), 'h44);
    tick();
    chk("tri_c3_p1", 64'({wen1, waddr1}), 64'({1'b1, 5'd7}));
    chk("tri_c3_d1", 64'(wdata1), 'h77);
    chk("tri_c3_wen2", 64'(wen2), 0);

    // Same-rd conflict: rr back at LSU, LSU wins first
    lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 'hAAAA;
    mdu_valid = 1; mdu_rd = 5'd9; mdu_data = 'hBBBB;
    tick();
    idle();
    chk("same_pend", 64'(pend_mask), 64'h200);
    chk("same_mdu_ready", 64'(mdu_ready), 0);
    stall_inc();
    tick();
    chk("same_c2_p1", 64'({wen1, waddr1}), 64'({1'b1, 5'd9}));
    chk("same_c2_d1", 64'(wdata1), 'hAAAA);
    chk("same_c2_wen2", 64'(wen2), 0);
    tick();
    chk("same_c3_p1", 64'({wen1, waddr1}), 64'({1'b1, 5'd9}));
    chk("same_c3_d1", 64'(wdata1), 'hBBBB);
    chk("same_c3_wen2", 64'(wen2), 0);

    // r0 result is dropped silently
    alu_valid = 1; alu_rd = 5'd0; alu_data = 'hFFFF;
    tick();
    idle();
    chk("r0_pend", 64'(pend_mask), 0);
    chk("r0_ready", 64'(alu_ready), 1);
    tick();
    chk("r0_wen", 64'({wen1, wen2}), 0);
    chk("r0_ready2", 64'(alu_ready), 1);
    tick();
    chk("r0_wen_late", 64'({wen1, wen2}), 0);
    chk("stall_total", 64'(stall_cnt), 64'(exp_stall));

    // Back-to-back ALU stream, one write per cycle
    for (int k = 1; k <= 6; k++) begin
      alu_valid = 1; alu_rd = 5'(k); alu_data = DW'('h100 + k);
      chk($sformatf("b2b_ready_%0d", k), 64'(alu_ready), 1);
      tick();
      if (k >= 2) begin
        chk($sformatf("b2b_p1_%0d", k), 64'({wen1, waddr1}), 64'({1'b1, 5'(k - 1)}));
        chk($sformatf("b2b_d1_%0d", k), 64'(wdata1), 64'('h100 + k - 1));
        chk($sformatf("b2b_wen2_%0d", k), 64'(wen2), 0);
      end
    end
    // rd=6 is buffered; asynchronous reset mid-cycle discards it
    chk("b2b_pend6", 64'(pend_mask), 64'h40);
    #2 resetn = 0;
    #1;
    chk("async_wen1", 64'(wen1), 0);
    chk("async_waddr1", 64'(waddr1), 0);
    chk("async_pend", 64'(pend_mask), 0);
    chk("async_stall", 64'(stall_cnt), 0);
    tick();
    idle();
    resetn = 1;
    tick();
    chk("after_rst_wen1", 64'(wen1), 0);
    tick();
    chk("after_rst_wen1b", 64'({wen1, wen2}), 0);
    chk("after_rst_pend", 64'(pend_mask), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter sitting directly upstream of the dual-write-port register file. It collects results from three execution sources (LSU, MUL/DIV, ALU), buffers one result per source, and issues up to two register writes per cycle onto the register file's write port 1 and write port 2. It never issues two same-cycle writes to the same register, so the register file's write-crash path is never exercised. It also exports a pending-write mask that the decode scoreboard uses for hazard detection.

## Interface
- No parameters. Data width is the global `GRLEN` macro.
- clk  in  1  core clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- lsu_valid / lsu_ready  in / out  1  LSU result handshake.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  `GRLEN  LSU result.
- mdu_valid, mdu_ready, mdu_rd, mdu_data: same shape as the LSU ports, for the MUL/DIV source.
- alu_valid, alu_ready, alu_rd, alu_data: same shape as the LSU ports, for the ALU source.
- wen1  out  1  write-port-1 enable to the register file (registered).
- waddr1  out  5  write-port-1 address (registered).
- wdata1  out  `GRLEN  write-port-1 data (registered).
- wen2, waddr2, wdata2: same shape as the port-1 outputs, for write port 2.
- pend_mask  out  32  bit r is set when any source buffer holds rd==r; bit 0 is always 0.
- stall_cnt  out  32  count of arbitration stall cycles (see Configuration).

## Operation
- Each source has a one-entry buffer holding {full, rd, data}.
- Ready: src_ready = !full | drained_this_cycle. This is combinational from the buffer state and the current grant, with no dependence on src_valid.
- A transfer occurs when src_valid & src_ready. The buffer loads on the following clock edge.
- rd == 0 entries:
  - They drain the same cycle they are buffered.
  - They consume no port, are never written, and never block other sources.
- Round-robin arbitration uses a pointer rr over states LSU → MDU → ALU → LSU. rr resets to LSU.
- Scan order starts at rr and considers full buffers with nonzero rd:
  - The first candidate is granted to port 1.
  - The next candidate is granted to port 2 only if its rd differs from the port-1 rd. Otherwise it waits; the scan never skips past it to a third source.
- rr advances to the source after the last granted one. If nothing is granted, rr holds.
- Granted buffers clear on the clock edge. Port outputs load {1, rd, data} for a grant and {0, 0, 0} otherwise.
- Ordering:
  - Per-source order is preserved.
  - Cross-source write-after-write order is guaranteed by decode, which stalls on pend_mask. This block does not reorder beyond arbitration.
- pend_mask is combinational from buffer state only and excludes the registered port outputs. The register file forwards those outputs itself.

## Timing
- Reset (asynchronous, resetn low):
  - All buffers are empty and rr = LSU.
  - wen1, wen2, waddr*, wdata* are 0; pend_mask is 0; stall_cnt is 0.
  - All *_ready outputs are 1.
- Latency: accept at edge N → buffered at N → granted in cycle N+1 → wenX high in cycle N+2 → register file updated at the end of N+2. The register file's read-after-write forwarding makes the value visible to readers in cycle N+2.
- Throughput: 2 writes per cycle sustained when rds differ. A full buffer that is granted accepts a new result in the same cycle (back-to-back).
- Boundary cases:
  - All three buffers full with distinct rd: two writes issue, and the third issues next cycle.
  - All three buffers full with the same rd: one write per cycle.
  - Reset asserted mid-operation discards buffered results with no writes issued.
  - wen2 is never high with waddr2 == waddr1.

## Configuration
- WB_STALL_CNT_EN defined:
  - stall_cnt increments (wrapping at 2^32) every cycle in which at least one full buffer with nonzero rd is not granted.
- WB_STALL_CNT_EN undefined:
  - stall_cnt is tied to 0 and no counter flop exists.
  - All other behaviour is identical.

## Structure
- Shared package holds:
  - The source index enum (SRC_LSU = 0, SRC_MDU = 1, SRC_ALU = 2) and NUM_SRC = 3.
  - The wb_entry struct {full, rd[4:0], data[`GRLEN-1:0]}.
- One sub-module, wb_src_buf, implements a single source buffer with its ready/load/drain logic. It is instantiated three times.
- The arbiter, rr pointer, output registers and counter live in the top module.

## Test plan
- Reset: hold resetn low for 3 cycles while all valids are 1 → all outputs are 0, all readies are 1, and no transfer occurs.
- Single write: alu {rd=5, data=0x1234} in cycle 0 → wen1=1, waddr1=5, wdata1=0x1234 in cycle 2; wen2=0.
- Three distinct writes: lsu rd=3, mdu rd=4, alu rd=7 in the same cycle with rr=LSU → cycle 2 shows port1=r3, port2=r4; cycle 3 shows port1=r7; rr ends at LSU.
- Same-rd conflict: lsu rd=9 (data A) and mdu rd=9 (data B) together → cycle 2 shows only port1=r9 with A; cycle 3 shows port1=r9 with B. wen2 stays 0 throughout, and stall_cnt is +1 when WB_STALL_CNT_EN is defined.
- r0 filter: alu rd=0, data=0xFFFF → no wen in any cycle, pend_mask stays 0, and alu_ready stays 1.
- Back-to-back with mid-stream reset: ALU valid every cycle with rd=1,2,3,… → one write per cycle in order. resetn dropped asynchronously mid-stream → outputs are 0 immediately and buffered entries are never written.
